// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side packer: FSM encoding and lane-mask constants.
package fifo_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam int unsigned MAX_LANES = 16;
  localparam logic [MAX_LANES-1:0] KEEP_ALL = '1;

endpackage

// File: rtl/pack_acc.sv
// Lane accumulator: writes one word per cycle into the next free lane and reads all lanes out in parallel.
module pack_acc #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK_RATIO = 4,
  parameter int unsigned CNT_W      = $clog2(PACK_RATIO + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en_i,
  input  logic [DATA_WIDTH-1:0]            wr_data_i,
  input  logic                             clr_i,
  output logic [CNT_W-1:0]                 cnt_o,
  output logic [PACK_RATIO*DATA_WIDTH-1:0] data_o
);

  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] lane_q, lane_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  logic [CNT_W-1:0]                      wr_idx;

  // A clear and a write in the same cycle restart the word at lane 0.
  always_comb begin
    lane_d = lane_q;
    cnt_d  = cnt_q;
    wr_idx = clr_i ? '0 : cnt_q;
    if (clr_i) begin
      lane_d = '0;
      cnt_d  = '0;
    end
    if (wr_en_i) begin
      for (int k = 0; k < int'(PACK_RATIO); k++) begin
        if (wr_idx == CNT_W'(k)) lane_d[k] = wr_data_i;
      end
      cnt_d = wr_idx + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      cnt_q  <= '0;
    end else begin
      lane_q <= lane_d;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign data_o = lane_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains a registered-read FIFO, packs PACK_RATIO words per output beat, and emits partial beats on flush.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PACK_RATIO = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_data,
  output logic                             fifo_rd_en,
  input  logic                             flush,
  output logic                             flush_busy,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
  output logic [PACK_RATIO-1:0]            m_keep
);

  localparam int unsigned CNT_W = $clog2(PACK_RATIO + 1);
  localparam logic [CNT_W:0] FULL = (CNT_W + 1)'(PACK_RATIO);

  state_e                            state_q;
  logic                              alive_q;
  logic                              rd_pend_q;
  logic                              m_valid_q;
  logic [DATA_WIDTH*PACK_RATIO-1:0]  m_data_q;
  logic [PACK_RATIO-1:0]             m_keep_q, m_keep_d;

  logic [CNT_W-1:0]                  cnt;
  logic [DATA_WIDTH*PACK_RATIO-1:0]  acc_data;
  logic [CNT_W:0]                    inflight;
  logic                              acc_full, acc_ready, xfer, rd_en;

  assign inflight  = {1'b0, cnt} + {{CNT_W{1'b0}}, rd_pend_q};
  assign acc_full  = ({1'b0, cnt} == FULL);
  assign acc_ready = acc_full | ((state_q == FLUSH) & ~rd_pend_q & (cnt != '0));
  assign xfer      = acc_ready & (~m_valid_q | m_ready);

  // alive_q keeps the pop request low while reset is held, even with data waiting.
  assign rd_en = alive_q & ~fifo_empty & (state_q == RUN) &
                 ((inflight < FULL) | (acc_full & ~m_valid_q));

  assign m_keep_d = ~(KEEP_ALL[PACK_RATIO-1:0] << cnt);

  pack_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .PACK_RATIO (PACK_RATIO),
    .CNT_W      (CNT_W)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (rd_pend_q),
    .wr_data_i (fifo_data),
    .clr_i     (xfer),
    .cnt_o     (cnt),
    .data_o    (acc_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      alive_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
    end else begin
      alive_q   <= 1'b1;
      rd_pend_q <= rd_en;
      case (state_q)
        RUN:   if (flush) state_q <= FLUSH;
        FLUSH: if (!rd_pend_q && ((cnt == '0) || xfer)) state_q <= RUN;
        default: state_q <= RUN;
      endcase
      if (xfer) begin
        m_valid_q <= 1'b1;
        m_data_q  <= acc_data;
        m_keep_q  <= m_keep_d;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign fifo_rd_en = rd_en;
  assign flush_busy = (state_q == FLUSH);
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_keep     = m_keep_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a behavioural registered-read FIFO in front of it.
module tb_fifo_rd_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic        flush;
  logic        flush_busy;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;

  fifo_rd_packer #(.DATA_WIDTH(8), .PACK_RATIO(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .flush_busy (flush_busy),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_keep     (m_keep)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [7:0] first;
    logic [7:0] stride;
    bit         do_flush;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
  } vec_t;

  vec_t        vecs[5];
  logic [7:0]  fq[$];
  logic [31:0] out_data[$];
  logic [3:0]  out_keep[$];
  int          out_cyc[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_out();
    out_data.delete();
    out_keep.delete();
    out_cyc.delete();
  endtask

  task automatic step();
    bit rd;
    #1;
    rd = fifo_rd_en;
    if (m_valid && m_ready) begin
      out_data.push_back(m_data);
      out_keep.push_back(m_keep);
      out_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rd && fq.size() > 0) fifo_data = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] exp_stream;
    bit          drained;

    vecs[0] = '{4, 8'h11, 8'h11, 1'b0, 32'h44332211, 4'b1111};
    vecs[1] = '{3, 8'hA1, 8'h11, 1'b1, 32'h00C3B2A1, 4'b0111};
    vecs[2] = '{1, 8'h5A, 8'h00, 1'b1, 32'h0000005A, 4'b0001};
    vecs[3] = '{2, 8'h10, 8'h01, 1'b1, 32'h00001110, 4'b0011};
    vecs[4] = '{4, 8'hF0, 8'h01, 1'b0, 32'hF3F2F1F0, 4'b1111};

    // reset with data apparently available
    rst_n = 1'b0; fifo_empty = 1'b0; fifo_data = 8'h00; flush = 1'b0; m_ready = 1'b1;
    #3;
    chk("rst_rd_en", fifo_rd_en, 1'b0);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_keep", m_keep, 4'b0);
    chk("rst_data", m_data, 32'h0);
    chk("rst_busy", flush_busy, 1'b0);
    steps(2);
    chk("rst_rd_en_held", fifo_rd_en, 1'b0);
    fifo_empty = 1'b1;
    rst_n = 1'b1;
    steps(2);

    for (int v = 0; v < 5; v++) begin
      clear_out();
      for (int b = 0; b < vecs[v].n; b++) push(vecs[v].first + 8'(b) * vecs[v].stride);
      steps(12);
      if (vecs[v].do_flush) begin
        chk($sformatf("v%0d_pre_flush_quiet", v), out_data.size(), 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk($sformatf("v%0d_busy_hi", v), flush_busy, 1'b1);
        step();
        chk($sformatf("v%0d_busy_lo", v), flush_busy, 1'b0);
        chk($sformatf("v%0d_valid", v), m_valid, 1'b1);
      end
      steps(4);
      chk($sformatf("v%0d_count", v), out_data.size(), 1);
      if (out_data.size() > 0) begin
        chk($sformatf("v%0d_data", v), out_data[0], vecs[v].exp_data);
        chk($sformatf("v%0d_keep", v), out_keep[0], vecs[v].exp_keep);
      end
    end

    // streaming: one word every five cycles
    clear_out();
    for (int b = 0; b < 16; b++) push(8'(b));
    steps(30);
    chk("stream_count", out_data.size(), 4);
    for (int w = 0; w < 4 && w < out_data.size(); w++) begin
      exp_stream = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      chk($sformatf("stream_data%0d", w), out_data[w], exp_stream);
      chk($sformatf("stream_keep%0d", w), out_keep[w], 4'b1111);
      if (w > 0) chk($sformatf("stream_gap%0d", w), out_cyc[w] - out_cyc[w-1], 5);
    end

    // backpressure: accumulator fills behind a stalled output
    clear_out();
    m_ready = 1'b0;
    for (int b = 0; b < 12; b++) push(8'h20 + 8'(b));
    steps(8);
    held = m_data;
    steps(12);
    #1;
    chk("bp_valid", m_valid, 1'b1);
    chk("bp_data", m_data, 32'h23222120);
    chk("bp_stable", m_data, held);
    chk("bp_rd_en", fifo_rd_en, 1'b0);
    chk("bp_left", fq.size(), 4);
    m_ready = 1'b1;
    steps(20);
    chk("bp_count", out_data.size(), 3);
    if (out_data.size() == 3) begin
      chk("bp_w0", out_data[0], 32'h23222120);
      chk("bp_w1", out_data[1], 32'h27262524);
      chk("bp_w2", out_data[2], 32'h2B2A2928);
    end

    // flush on the cycle the last popped word lands
    clear_out();
    push(8'h01); push(8'h02); push(8'h03);
    drained = 1'b0;
    for (int i = 0; i < 10 && !drained; i++) begin
      step();
      if (fq.size() == 0) drained = 1'b1;
    end
    chk("land_drain_bound", drained, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("land_busy_hi", flush_busy, 1'b1);
    steps(6);
    chk("land_count", out_data.size(), 1);
    if (out_data.size() > 0) begin
      chk("land_data", out_data[0], 32'h00030201);
      chk("land_keep", out_keep[0], 4'b0111);
    end
    chk("land_busy_lo", flush_busy, 1'b0);

    // flush with nothing accumulated
    clear_out();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("empty_busy_hi", flush_busy, 1'b1);
    step();
    chk("empty_busy_lo", flush_busy, 1'b0);
    steps(4);
    chk("empty_no_word", out_data.size(), 0);

    // reset with two lanes held
    clear_out();
    push(8'hE1); push(8'hE2);
    steps(8);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_keep", m_keep, 4'b0);
    chk("mid_rst_data", m_data, 32'h0);
    chk("mid_rst_busy", flush_busy, 1'b0);
    steps(2);
    rst_n = 1'b1;
    for (int b = 0; b < 4; b++) push(8'h31 + 8'(b));
    steps(14);
    chk("mid_rst_count", out_data.size(), 1);
    if (out_data.size() > 0) begin
      chk("mid_rst_word", out_data[0], 32'h34333231);
      chk("mid_rst_wkeep", out_keep[0], 4'b1111);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
